// File: rtl/pr_axi_pkg.sv
// rtl/pr_axi_pkg.sv - shared AXI read IDs, beat size and softreg constants for the PageRank engine
package pr_axi_pkg;

  localparam int RID_VERT = 0;
  localparam int RID_IE   = 1;
  localparam int RID_PR   = 2;

  localparam int N_RD_REQ = 3;

  localparam logic [2:0] AXSIZE_64B = 3'b110;

  localparam logic [31:0] SR_ADDR_DONE  = 32'h0000_0010;
  localparam logic [31:0] SR_ADDR_ROUND = 32'h0000_0014;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: first eligible index at or after ptr, with wrap-around
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic [PW-1:0] next_ptr,
  output logic          any_grant
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    next_ptr  = ptr;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_grant && eligible[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        next_ptr   = (idx + 1 == N) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/pr_read_arbiter.sv
// rtl/pr_read_arbiter.sv - shares one AXI read port between the vertex, in-edge and PR-score readers
module pr_read_arbiter
  import pr_axi_pkg::*;
#(
  parameter int N_REQ   = N_RD_REQ,
  parameter int ADDR_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*8-1:0]      req_len,
  output logic [N_REQ-1:0]        req_ready,
  output logic [15:0]             arid_m,
  output logic [ADDR_W-1:0]       araddr_m,
  output logic [7:0]              arlen_m,
  output logic [2:0]              arsize_m,
  output logic                    arvalid_m,
  input  logic                    arready_m,
  input  logic [15:0]             rid_m,
  input  logic                    rlast_m,
  input  logic                    rvalid_m,
  output logic                    rready_m,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [N_REQ*3-1:0]      outstanding,
  output logic                    idle,
  output logic                    err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [2:0]        credit [N_REQ];
  logic [PW-1:0]     ptr, next_ptr, grant_idx;
  logic [N_REQ-1:0]  eligible, grant, cr_inc, cr_dec;
  logic              any_grant, slot_free, ar_hs, r_hs, rid_known, all_zero;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_len;

  assign slot_free = !arvalid_m || arready_m;
  assign ar_hs     = arvalid_m && arready_m;
  assign arsize_m  = AXSIZE_64B;

  // An AR sitting in the slot already owns a credit even if it drains this cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] &&
                    (({1'b0, credit[i]} + {3'b000, (arvalid_m && arid_m == 16'(i))}) < 4'(MAX_OUT));
    end
  end

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .next_ptr  (next_ptr),
    .any_grant (any_grant)
  );

  assign req_ready = slot_free ? grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*8 +: 8];
      end
    end
  end

  // Unknown IDs are swallowed so a stray beat can never stall the port.
  always_comb begin
    resp_valid = '0;
    rready_m   = 1'b1;
    rid_known  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rid_m == 16'(i)) begin
        rid_known     = 1'b1;
        rready_m      = resp_ready[i];
        resp_valid[i] = rvalid_m;
      end
    end
  end

  assign r_hs = rvalid_m && rready_m;

  always_comb begin
    cr_inc = '0;
    cr_dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cr_inc[i] = ar_hs && (arid_m == 16'(i));
      cr_dec[i] = r_hs && rlast_m && (rid_m == 16'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arvalid_m <= 1'b0;
      arid_m    <= '0;
      araddr_m  <= '0;
      arlen_m   <= '0;
      ptr       <= '0;
    end else if (slot_free) begin
      arvalid_m <= any_grant;
      if (any_grant) begin
        arid_m   <= 16'(grant_idx);
        araddr_m <= {sel_addr[ADDR_W-1:6], 6'b0};
        arlen_m  <= sel_len;
        ptr      <= next_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) credit[i] <= '0;
      err <= 1'b0;
    end else begin
      if (rvalid_m && !rid_known) err <= 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (cr_inc[i] && !cr_dec[i]) begin
          credit[i] <= credit[i] + 3'd1;
        end else if (cr_dec[i] && !cr_inc[i]) begin
          if (credit[i] == 3'd0) err <= 1'b1;
          else credit[i] <= credit[i] - 3'd1;
        end
      end
    end
  end

  always_comb begin
    outstanding = '0;
    all_zero    = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      outstanding[i*3 +: 3] = credit[i];
      if (credit[i] != 3'd0) all_zero = 1'b0;
    end
  end

  assign idle = !arvalid_m && all_zero;

endmodule

// File: tb/tb_pr_read_arbiter.sv
// tb/tb_pr_read_arbiter.sv - randomized bench for pr_read_arbiter against a behavioural model
module tb_pr_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*8-1:0]  req_len = '0;
  logic [N-1:0]    req_ready;
  logic [15:0]     arid_m;
  logic [AW-1:0]   araddr_m;
  logic [7:0]      arlen_m;
  logic [2:0]      arsize_m;
  logic            arvalid_m;
  logic            arready_m = 1'b0;
  logic [15:0]     rid_m = '0;
  logic            rlast_m = 1'b0;
  logic            rvalid_m = 1'b0;
  logic            rready_m;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '0;
  logic [N*3-1:0]  outstanding;
  logic            idle;
  logic            err;

  always #5 clk = ~clk;

  pr_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m), .rready_m(rready_m),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .outstanding(outstanding), .idle(idle), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model state: credits per requester, pointer, the pending AR and the sticky error.
  int          m_cred [N];
  int          m_ptr;
  bit          m_av;
  int          m_id;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  bit          m_err;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_cred[i] = 0;
    m_ptr = 0; m_av = 0; m_id = 0; m_addr = '0; m_len = '0; m_err = 0;
  endfunction

  function automatic int model_grant();
    int g = -1;
    if (!m_av || arready_m) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        int held = m_cred[j] + ((m_av && m_id == j) ? 1 : 0);
        if (g < 0 && req_valid[j] && held < MO) g = j;
      end
    end
    return g;
  endfunction

  task automatic compare_outputs();
    int g = model_grant();
    bit known = (rid_m < 16'(N));
    logic [N-1:0] exp_rv = '0;
    bit exp_rr = known ? resp_ready[rid_m] : 1'b1;
    bit exp_idle = !m_av;
    if (known && rvalid_m) exp_rv[rid_m] = 1'b1;
    for (int i = 0; i < N; i++) if (m_cred[i] != 0) exp_idle = 0;
    check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
    check("rready_m", 64'(rready_m), 64'(exp_rr));
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    check("arvalid_m", 64'(arvalid_m), 64'(m_av));
    check("arid_m", 64'(arid_m), 64'(m_id));
    check("araddr_m", araddr_m, m_addr);
    check("arlen_m", 64'(arlen_m), 64'(m_len));
    check("arsize_m", 64'(arsize_m), 64'(3'b110));
    check("outstanding", 64'(outstanding), 64'({3'(m_cred[2]), 3'(m_cred[1]), 3'(m_cred[0])}));
    check("idle", 64'(idle), 64'(exp_idle));
    check("err", 64'(err), 64'(m_err));
  endtask

  function automatic void model_advance();
    int g = model_grant();
    bit known = (rid_m < 16'(N));
    bit rr = known ? resp_ready[rid_m] : 1'b1;
    bit ar_hs = m_av && arready_m;
    bit last_hs = rvalid_m && rr && rlast_m && known;
    if (rvalid_m && !known) m_err = 1;
    for (int i = 0; i < N; i++) begin
      bit inc = ar_hs && m_id == i;
      bit dec = last_hs && int'(rid_m) == i;
      if (inc && !dec) m_cred[i]++;
      else if (dec && !inc) begin
        if (m_cred[i] == 0) m_err = 1;
        else m_cred[i]--;
      end
    end
    if (!m_av || arready_m) begin
      m_av = (g >= 0);
      if (g >= 0) begin
        m_id   = g;
        m_addr = req_addr[g*AW +: AW] & ~64'h3F;
        m_len  = req_len[g*8 +: 8];
        m_ptr  = (g + 1) % N;
      end
    end
  endfunction

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    #1;
    compare_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req_valid = '0; arready_m = 1'b0; rvalid_m = 1'b0; rlast_m = 1'b0;
    rid_m = '0; resp_ready = '0;
  endtask

  task automatic do_reset();
    quiet();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(posedge clk);
    #1;
    compare_outputs();
    reset_n = 1'b1;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = {$urandom, $urandom};
      req_len[i*8 +: 8]    = 8'($urandom);
    end
  endtask

  int beat;

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single requester 1, unaligned address.
    rand_addrs();
    req_addr[AW +: AW] = 64'h1048;
    req_valid = 3'b010; arready_m = 1'b1;
    step();
    req_valid = '0;
    repeat (3) step();

    // All requesters continuously, no responses: fill every credit.
    req_valid = 3'b111; arready_m = 1'b1;
    for (int c = 0; c < 16; c++) begin rand_addrs(); step(); end

    // Drain every burst with single-beat responses.
    req_valid = '0; rvalid_m = 1'b1; rlast_m = 1'b1; resp_ready = 3'b111;
    for (int c = 0; c < 12; c++) begin rid_m = 16'(c % N); step(); end
    quiet();
    step();

    // Requester 2 held behind a stalled arready.
    rand_addrs();
    req_valid = 3'b100; arready_m = 1'b0;
    repeat (6) step();
    req_valid = '0; arready_m = 1'b1;
    step();
    quiet();
    step();

    // Four-beat burst on ID 0 with toggling resp_ready.
    req_valid = 3'b001; arready_m = 1'b1;
    step();
    req_valid = '0;
    step();
    arready_m = 1'b0; rvalid_m = 1'b1; rid_m = 16'd0; beat = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      rlast_m = (beat == 3);
      resp_ready = {2'b00, 1'(c % 2)};
      if (resp_ready[0]) beat++;
      step();
    end
    check("burst_done", 64'(beat), 64'd4);
    quiet();
    step();

    // AR handshake on ID 2 coincident with its rlast handshake; then an unknown ID.
    req_valid = 3'b100; arready_m = 1'b1;
    step();
    req_valid = 3'b100;
    step();
    req_valid = '0; arready_m = 1'b0;
    step();
    arready_m = 1'b1; rvalid_m = 1'b1; rid_m = 16'd2; rlast_m = 1'b1; resp_ready = 3'b100;
    step();
    quiet();
    rvalid_m = 1'b1; rid_m = 16'd5; rlast_m = 1'b1;
    step();
    quiet();
    step();

    // Reset with bursts outstanding, then a late rlast on ID 0.
    do_reset();
    req_valid = 3'b001; arready_m = 1'b1;
    repeat (3) step();
    do_reset();
    rvalid_m = 1'b1; rid_m = 16'd0; rlast_m = 1'b1; resp_ready = 3'b001;
    step();
    quiet();
    step();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rand_addrs();
      req_valid  = 3'($urandom);
      arready_m  = ($urandom_range(0, 3) != 0);
      rvalid_m   = ($urandom_range(0, 1) != 0);
      rlast_m    = ($urandom_range(0, 2) != 0);
      resp_ready = 3'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        rid_m = 16'd5;
      end else begin
        int j = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) if (m_cred[j] == 0) j = (j + 1) % N;
        rid_m = 16'(j);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_read_arbiter.md
# pr_read_arbiter

Shares the single AXI read-address/read-data port of the PageRank engine between its three read requesters: vertex stream, in-edge stream and random PageRank-score reads. It selects requesters round-robin, tags each accepted AR with the requester index as `arid_m`, and limits outstanding bursts per requester with credit counters. It routes R beats back to the owning requester by `rid_m` and reports when the port has drained, so round sequencing can switch safely.

## Interface
- `N_REQ`, 3, number of requesters; requester index = AXI ID (0 vertex, 1 in-edge, 2 PR).
- `ADDR_W`, 64, AXI address width.
- `MAX_OUT`, 4, maximum outstanding bursts per requester (≥1).
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester read request.
- `req_addr`  in  N_REQ*ADDR_W  request address; slice i belongs to requester i.
- `req_len`  in  N_REQ*8  AXI burst length−1 per requester.
- `req_ready`  out  N_REQ  request accepted this cycle (one-hot or zero).
- `arid_m`  out  16  AXI read ID = granted requester index.
- `araddr_m`  out  ADDR_W  registered address with bits [5:0] forced to 0.
- `arlen_m`  out  8  registered burst length.
- `arsize_m`  out  3  constant 3'b110 (64-byte beats).
- `arvalid_m`  out  1  AR valid.
- `arready_m`  in  1  AR ready.
- `rid_m`  in  16  R ID.
- `rlast_m`  in  1  last beat of burst.
- `rvalid_m`  in  1  R valid.
- `rready_m`  out  1  R ready.
- `resp_valid`  out  N_REQ  beat valid for requester i; `rdata_m` is routed externally.
- `resp_ready`  in  N_REQ  requester i accepts the beat.
- `outstanding`  out  N_REQ*3  per-requester credit count.
- `idle`  out  1  no AR pending and all credits zero.
- `err`  out  1  sticky: unknown `rid_m` or credit underflow.

## Operation
- **AR slot:** a one-entry register holds ID, address, length and valid.
  - The slot is free when `!arvalid_m`, or when `arvalid_m & arready_m` (drained this cycle).
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and `credit[i] < MAX_OUT`.
  - A requester whose AR is in the slot and not yet handshaken counts as already holding a credit.
- **Grant:** when the slot is free, grant the first eligible requester at or after round-robin pointer `ptr`, searching in increasing index order with wrap-around.
  - Assert `req_ready[g]`, load the slot, and set `ptr <= (g+1) mod N_REQ`.
  - With no eligible requester, `ptr` is unchanged.
- **AXI stability:** while `arvalid_m & !arready_m`, `arid_m`, `araddr_m` and `arlen_m` hold stable and no grant occurs.
- **Credits:** `credit[i]` increments on an AR handshake with ID i. It decrements on an R handshake where `rlast_m` is high and `rid_m` is i.
  - Increment and decrement in the same cycle leave the count unchanged.
  - A decrement at 0 saturates at 0 and sets `err`.
- **Response routing** (combinational):
  - `resp_valid[i] = rvalid_m & (rid_m == i)`.
  - `rready_m = resp_ready[rid_m]` when `rid_m < N_REQ`. Otherwise `rready_m = 1`, the beat is discarded and `err` is set.
- **Idle:** `idle = !arvalid_m & (all credit == 0)`.
- **Reset** (asynchronous, any time): `arvalid_m=0`, `arid_m=0`, `araddr_m=0`, `arlen_m=0`, all credits 0, `ptr=0`, `err=0`, `idle=1`.
  - Bursts in flight at reset are lost. Their late `rlast` beats set `err` through the underflow rule.

## Timing
- Grant to `arvalid_m`: 1 cycle, since `req_ready` is combinational and the slot is registered.
- Back-to-back AR issue is one per cycle when `arready_m` is held high.
- `resp_valid` and `rready_m` have zero latency from the R inputs; there is no R buffering.
- `outstanding`, `idle` and `err` are registered and reflect handshakes from the previous cycle.
- The `idle` rise follows the final `rlast` handshake by 1 cycle.

## Structure
- Shared package `pr_axi_pkg`:
  - `RID_VERT=0`, `RID_IE=1`, `RID_PR=2`.
  - `AXSIZE_64B=3'b110`.
  - `N_RD_REQ=3`.
  - The DONE/round softreg address constants, already in the shared constants.
- One sub-module, `rr_arbiter`: a parameterised round-robin priority picker taking eligible mask and `ptr`, producing a one-hot grant and the next pointer.
- Credit counters, the AR slot and routing stay in the top module.

## Test plan
- Only requester 1 valid, `req_addr=0x1048`, `arready_m=1` → `req_ready=3'b010`; next cycle `arvalid_m=1`, `arid_m=1`, `araddr_m=0x1040`; `outstanding[1]` becomes 1.
- All three requesters valid continuously, `arready_m=1`, no responses, `MAX_OUT=4` → ARs issue with IDs 0,1,2,0,1,2,… until each credit reaches 4; then `arvalid_m` drops and `req_ready=0`.
- `arready_m` held 0 for 5 cycles with ID 2 pending → `araddr_m` and `arid_m` stay unchanged and `req_ready` stays 0; handshake occurs when ready rises.
- Four-beat burst returned on `rid_m=0` with `resp_ready[0]` toggling → `rready_m` follows `resp_ready[0]`; `credit[0]` decrements only on the `rlast` handshake.
- AR handshake on ID 2 in the same cycle as an `rlast` handshake on ID 2 → `credit[2]` unchanged; `rvalid_m` with `rid_m=5` → `rready_m=1`, no `resp_valid`, `err=1`.
- `reset_n` pulsed low while 2 bursts are outstanding → all outputs take reset values immediately; a subsequent `rlast` on ID 0 sets `err` and `credit[0]` stays 0.
